// File: rtl/epoch_alarm.sv
// Epoch alarm: fires when the running epoch reaches a programmable alarm time,
// optionally re-arming by a repeat period; sticky irq/missed plus a fixed-width pulse.
module epoch_alarm #(
  parameter int WIDTH        = 64,
  parameter int PERIOD_WIDTH = 32,
  parameter int PULSE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        i_time,
  input  logic [WIDTH-1:0]        i_alarm,
  input  logic                    alarm_le,
  input  logic [PERIOD_WIDTH-1:0] i_period,
  input  logic                    period_le,
  input  logic                    arm,
  input  logic                    disarm,
  input  logic                    irq_ack,
  output logic                    irq,
  output logic                    irq_pulse,
  output logic                    missed,
  output logic [1:0]              state
);

  localparam int CW = $clog2(PULSE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    FIRED = 2'b10
  } state_e;

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        alarm_q, alarm_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic                    irq_q, irq_d;
  logic                    missed_q, missed_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    fire;

  always_comb begin
    state_d  = state_q;
    alarm_d  = alarm_q;
    period_d = period_le ? i_period : period_q;
    fire     = 1'b0;
    if (alarm_le) alarm_d = i_alarm;

    // Compare uses the pre-load alarm; a same-edge load only affects later cycles.
    case (state_q)
      IDLE:  if (arm) state_d = ARMED;
      ARMED: begin
        if (disarm) state_d = IDLE;
        else if (i_time >= alarm_q) begin
          state_d = FIRED;
          fire    = 1'b1;
        end
      end
      FIRED: begin
        if (disarm || period_q == '0) state_d = IDLE;
        else begin
          state_d = ARMED;
          if (!alarm_le) alarm_d = alarm_q + WIDTH'(period_q);
        end
      end
      default: state_d = IDLE;
    endcase

    if (fire)         irq_d = 1'b1;
    else if (irq_ack) irq_d = 1'b0;
    else              irq_d = irq_q;

    if (fire && irq_q && !irq_ack) missed_d = 1'b1;
    else if (irq_ack)              missed_d = 1'b0;
    else                           missed_d = missed_q;

    // Refire during a pulse restarts it, so back-to-back pulses merge.
    if (fire)            cnt_d = CW'(PULSE_CYCLES);
    else if (cnt_q != 0) cnt_d = cnt_q - 1'b1;
    else                 cnt_d = cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      alarm_q  <= '0;
      period_q <= '0;
      irq_q    <= 1'b0;
      missed_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      alarm_q  <= alarm_d;
      period_q <= period_d;
      irq_q    <= irq_d;
      missed_q <= missed_d;
      cnt_q    <= cnt_d;
    end
  end

  assign irq       = irq_q;
  assign missed    = missed_q;
  assign irq_pulse = (cnt_q != '0);
  assign state     = state_q;

endmodule

// File: tb/tb_epoch_alarm.sv
// Directed bench for epoch_alarm with a time-based reference model checked every cycle.
module tb_epoch_alarm;

  localparam int PULSE = 16;

  logic        clk, rst;
  logic [63:0] i_time, i_alarm;
  logic [31:0] i_period;
  logic        alarm_le, period_le, arm, disarm, irq_ack;
  logic        irq, irq_pulse, missed;
  logic [1:0]  state;

  int n_tests = 0;
  int n_fail  = 0;
  int fire_cnt = 0;
  int hi;

  epoch_alarm #(.WIDTH(64), .PERIOD_WIDTH(32), .PULSE_CYCLES(PULSE)) dut (
    .clk(clk), .rst(rst), .i_time(i_time), .i_alarm(i_alarm), .alarm_le(alarm_le),
    .i_period(i_period), .period_le(period_le), .arm(arm), .disarm(disarm),
    .irq_ack(irq_ack), .irq(irq), .irq_pulse(irq_pulse), .missed(missed), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: armed flag, "fired last edge" flag, pulse end expressed as an edge number.
  bit          m_armed = 0, m_in_fire = 0, m_irq = 0, m_missed = 0, m_hit, m_due;
  logic [63:0] m_alarm = '0, m_nxt;
  logic [31:0] m_period = '0;
  int          m_edge = 0, m_pulse_until = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_armed = 0; m_in_fire = 0; m_irq = 0; m_missed = 0;
      m_alarm = '0; m_period = '0; m_edge = 0; m_pulse_until = 0;
    end else begin
      m_edge++;
      m_hit = !m_in_fire && m_armed && !disarm && (i_time >= m_alarm);
      m_nxt = m_alarm;
      if (m_in_fire) begin
        m_due     = !disarm && (m_period != 0);
        m_armed   = m_due;
        m_in_fire = 0;
        if (m_due) m_nxt = m_alarm + {32'd0, m_period};
      end else if (m_armed) begin
        if (disarm)     m_armed = 0;
        else if (m_hit) m_in_fire = 1;
      end else if (arm) m_armed = 1;
      if (alarm_le)  m_nxt = i_alarm;
      m_alarm = m_nxt;
      if (period_le) m_period = i_period;
      if (m_hit && m_irq && !irq_ack) m_missed = 1;
      else if (irq_ack)               m_missed = 0;
      if (m_hit)        m_irq = 1;
      else if (irq_ack) m_irq = 0;
      if (m_hit) m_pulse_until = m_edge + PULSE;
    end
  end

  always @(negedge clk) begin
    chk("irq", {63'd0, irq}, {63'd0, m_irq});
    chk("missed", {63'd0, missed}, {63'd0, m_missed});
    chk("irq_pulse", {63'd0, irq_pulse}, {63'd0, m_edge < m_pulse_until});
    chk("state", {62'd0, state}, {62'd0, m_in_fire ? 2'b10 : (m_armed ? 2'b01 : 2'b00)});
    if (state == 2'b10) fire_cnt++;
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
      alarm_le = 0; period_le = 0; arm = 0; disarm = 0; irq_ack = 0;
    end
  endtask

  task automatic load(input logic [63:0] a, input logic [31:0] p, input bit do_arm);
    i_alarm = a; alarm_le = 1; i_period = p; period_le = 1; arm = do_arm;
    cyc();
  endtask

  initial begin
    rst = 0; i_time = 0; i_alarm = 0; i_period = 0;
    alarm_le = 0; period_le = 0; arm = 0; disarm = 0; irq_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_irq", {63'd0, irq}, 64'd0);
    chk("rst_pulse", {63'd0, irq_pulse}, 64'd0);
    chk("rst_state", {62'd0, state}, 64'd0);
    rst = 1;

    // 1: one-shot at 100, 16-cycle pulse
    load(64'd100, 32'd0, 0);
    arm = 1; cyc();
    chk("t1_armed", {62'd0, state}, 64'd1);
    i_time = 98; cyc();
    i_time = 99; cyc();
    chk("t1_noirq", {63'd0, irq}, 64'd0);
    i_time = 100; cyc();
    chk("t1_irq", {63'd0, irq}, 64'd1);
    chk("t1_fired", {62'd0, state}, 64'd2);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (irq_pulse) hi++;
      cyc();
      if (i == 0) chk("t1_idle", {62'd0, state}, 64'd0);
    end
    chk("t1_pulse_len", hi, 64'd16);

    // 2: periodic 10/5 with ack every cycle, then without ack
    irq_ack = 1; i_time = 0; cyc();
    load(64'd10, 32'd5, 1);
    for (int t = 10; t <= 20; t++) begin
      i_time = t; irq_ack = 1; cyc();
    end
    chk("t2_missed_acked", {63'd0, missed}, 64'd0);
    disarm = 1; irq_ack = 1; i_time = 0; cyc();
    load(64'd10, 32'd5, 1);
    for (int t = 10; t <= 20; t++) begin
      i_time = t; cyc();
      if (t == 14) chk("t2_missed_pre15", {63'd0, missed}, 64'd0);
      if (t == 15) chk("t2_missed_15", {63'd0, missed}, 64'd1);
    end
    i_time = 24; cyc(3);
    chk("t2_hold_24", {62'd0, state}, 64'd1);
    i_time = 25; cyc();
    chk("t2_fire_25", {62'd0, state}, 64'd2);
    disarm = 1; irq_ack = 1; cyc();

    // 3: wraparound of alarm + period, immediate catch-up refire
    i_time = 64'hFFFF_FFFF_FFFF_FFFD;
    load(64'hFFFF_FFFF_FFFF_FFFD, 32'd5, 0);
    arm = 1; cyc();
    cyc();
    chk("t3_fire", {62'd0, state}, 64'd2);
    chk("t3_missed0", {63'd0, missed}, 64'd0);
    cyc();
    chk("t3_wrap_alarm", m_alarm, 64'd2);
    cyc();
    chk("t3_refire", {62'd0, state}, 64'd2);
    chk("t3_missed1", {63'd0, missed}, 64'd1);
    disarm = 1; irq_ack = 1; cyc();

    // 4: jump past several periods -> 4 catch-up fires
    i_time = 0;
    load(64'd50, 32'd10, 1);
    fire_cnt = 0;
    i_time = 85;
    cyc(12);
    chk("t4_fires", fire_cnt, 64'd4);
    chk("t4_armed", {62'd0, state}, 64'd1);
    chk("t4_model_alarm", m_alarm, 64'd90);
    disarm = 1; cyc();

    // 5: fire+ack same edge; disarm+compare same edge
    i_time = 0;
    load(64'd200, 32'd0, 1);
    i_time = 200; irq_ack = 1; cyc();
    chk("t5_irq_kept", {63'd0, irq}, 64'd1);
    chk("t5_missed_clr", {63'd0, missed}, 64'd0);
    cyc();
    irq_ack = 1; cyc();
    load(64'd300, 32'd0, 1);
    i_time = 400; disarm = 1; cyc();
    chk("t5_disarm_state", {62'd0, state}, 64'd0);
    chk("t5_disarm_noirq", {63'd0, irq}, 64'd0);

    // 6: async reset while FIRED and mid-pulse
    i_time = 0;
    load(64'd500, 32'd0, 1);
    i_time = 500; cyc();
    chk("t6_fired", {62'd0, state}, 64'd2);
    #2 rst = 0;
    #1;
    chk("t6_irq", {63'd0, irq}, 64'd0);
    chk("t6_pulse", {63'd0, irq_pulse}, 64'd0);
    chk("t6_missed", {63'd0, missed}, 64'd0);
    chk("t6_state", {62'd0, state}, 64'd0);
    cyc(2);
    rst = 1;
    cyc(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/epoch_alarm.md
Name: epoch_alarm

Overview:
- Downstream consumer of the 64-bit epoch timer output.
- Holds a programmable 64-bit alarm time and an optional 32-bit repeat period.
- When the running epoch reaches the alarm, raises a sticky interrupt plus a fixed-width external pulse.
- Alarm and period registers are loaded from the spi_fsm buffer path, in the same way the timer is loaded.

Parameters:
WIDTH, 64, epoch/alarm width in bits
PERIOD_WIDTH, 32, repeat-period width in bits; zero-extended to WIDTH for addition
PULSE_CYCLES, 16, clk cycles irq_pulse stays high per fire; must be >= 1

Ports:
clk  input  1  system clock (internal oscillator domain)
rst  input  1  asynchronous, active-low reset
i_time  input  WIDTH  current epoch from timer o_time
i_alarm  input  WIDTH  alarm value to load
alarm_le  input  1  load-enable for i_alarm, single-cycle
i_period  input  PERIOD_WIDTH  repeat period to load; 0 = one-shot
period_le  input  1  load-enable for i_period, single-cycle
arm  input  1  arm request, single-cycle
disarm  input  1  disarm request, single-cycle
irq_ack  input  1  clears irq and missed
irq  output  1  sticky alarm interrupt
irq_pulse  output  1  PULSE_CYCLES-wide pulse per fire, for an external pin
missed  output  1  sticky: a fire occurred while irq was still set
state  output  2  FSM state: 00 IDLE, 01 ARMED, 10 FIRED, 11 unused

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; alarm_reg=0; period_reg=0; irq=0; missed=0; irq_pulse=0; pulse counter=0.
- Loads:
  - alarm_le: alarm_reg<=i_alarm at the clock edge, in any state.
  - period_le: period_reg<=i_period at the clock edge, in any state.
  - Loads never change state.
  - A load takes effect for compares on the following cycle.
- FSM priority each edge: disarm > load/arm > fire.
- IDLE:
  - arm -> ARMED.
  - Otherwise hold.
- ARMED:
  - disarm -> IDLE.
  - Else if i_time >= alarm_reg (unsigned, using the pre-load register value) -> FIRED. At the same edge: irq<=1; pulse counter<=PULSE_CYCLES; missed<=1 if irq was already 1 and irq_ack=0 that cycle.
  - Otherwise hold.
  - arm while ARMED is ignored.
- FIRED (always exactly one cycle):
  - period_reg != 0 -> ARMED, with alarm_reg<=alarm_reg + zero-extended period_reg, modulo 2^WIDTH (wraps, no saturation).
  - period_reg == 0 -> IDLE.
  - disarm in FIRED -> IDLE; alarm_reg is not updated.
  - alarm_le in FIRED overrides the period add.
- Latency:
  - Compare true at edge k -> irq and irq_pulse high from edge k onward; state=FIRED for cycle k..k+1.
  - Earliest refire is edge k+2.
- Catch-up: if i_time jumps forward (e.g. timer reloaded via SPI) past several periods, the block fires once per 2 cycles until alarm_reg > i_time. missed is set on each fire after the first unless acked.
- The >= compare, rather than ==, guarantees firing when the epoch is loaded past the alarm.
- irq: set on fire, cleared by irq_ack. If irq_ack and a fire land on the same edge, the fire wins: irq stays 1 and missed is not set.
- irq_ack clears missed, except when the same edge's fire sets it per the rule above.
- irq_pulse = (pulse counter != 0).
  - Counter decrements each cycle while nonzero.
  - A fire while the counter is nonzero reloads it to PULSE_CYCLES; pulses merge.
  - Counter width = clog2(PULSE_CYCLES+1).
- Disarm does not clear irq, missed or the pulse counter.
- Reset mid-operation aborts immediately, including an in-progress pulse.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset, then load alarm=100, period=0, arm. Step i_time 98,99,100 -> irq=1 and irq_pulse=1 the cycle after i_time=100 is sampled; pulse lasts 16 cycles; state ARMED->FIRED->IDLE.
2. Load alarm=10, period=5, arm. Step i_time 10..20 -> fires at 10, 15, 20; alarm_reg=25 afterward; ack between fires keeps missed=0; no ack -> missed=1 after the fire at 15.
3. Load alarm=2^64-3, period=5, arm, with i_time=2^64-3 -> fire; alarm_reg wraps to 2; with i_time still at 2^64-3 -> immediate refire two cycles later (catch-up) and missed=1.
4. Armed with alarm=50, period=10. Jump i_time to 85 -> fires at alarm 50, 60, 70, 80, then ARMED with alarm_reg=90; exactly 4 fires, spaced 2 cycles apart.
5. Fire and irq_ack on the same edge -> irq stays 1, missed=0. disarm and compare-true on the same edge -> IDLE, no fire.
6. Assert rst low mid-pulse while in FIRED -> all outputs 0 and state=IDLE immediately, without waiting for a clk edge.
